// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg: elastic valid/ready pipeline register with a two-entry
// (main + skid) store, so that in_ready comes straight from a flop and never
// combinationally from out_ready. It sustains one word per cycle with one
// cycle of latency, and it supports a synchronous pipeline flush.
module skid_pipe_reg #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   count
);

    // Occupancy states: EMPTY holds no word, ONE holds a word in main,
    // FULL holds the oldest word in main and the next one in skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_main;
    logic [N-1:0]   r_skid;

    logic           w_in_fire;
    logic           w_out_fire;

    // Map the state to the number of held words.
    function automatic logic [1:0] occupancy(input state_t s);
        case (s)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    endfunction

    // Every handshake output is decoded from registered state only. This keeps
    // out_ready out of the in_ready cone.
    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_main;
    assign count      = occupancy(r_state);

    assign w_in_fire  = in_valid  & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Occupancy FSM and the data registers. Reset clears everything. Flush only
    // empties the FSM and leaves main/skid untouched, because they are not
    // observable while EMPTY.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            // A word offered in this cycle is dropped on purpose. A word taken
            // downstream in this cycle has already been consumed.
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        r_state <= ONE;
                        r_main  <= in_data;
                    end
                end
                ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        // Main is stalled. Park the new word behind it.
                        r_state <= FULL;
                        r_skid  <= in_data;
                    end else if (w_in_fire && w_out_fire) begin
                        // Full-rate streaming: replace the consumed word.
                        r_state <= ONE;
                        r_main  <= in_data;
                    end else if (w_out_fire) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain matters.
                    if (w_out_fire) begin
                        r_state <= ONE;
                        r_main  <= r_skid;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Bench for skid_pipe_reg: it runs directed scenarios and then a random
// stream. A queue scoreboard receives each word when the bench offers it and
// the block accepts it, and the scoreboard predicts count, ready, valid and
// data in every cycle.
module tb_skid_pipe_reg;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         flush;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   count;

    skid_pipe_reg #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [N-1:0] sb_q[$];
    bit           model_ok = 1'b0;
    bit           prev_stall = 1'b0;
    logic [N-1:0] prev_data = '0;
    int           max_count = 0;
    int           n_out = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle. Inputs are driven just after the rising edge, and the
    // outputs are checked at the falling edge before the block acts on them.
    task automatic step(input logic iv, input logic [N-1:0] id, input logic ordy,
                        input logic fl, input logic rst, input bit full_chk);
        logic ir_before;
        bit   in_f;
        bit   out_f;
        int   sz;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(negedge clk);
        sz = sb_q.size();
        if (model_ok) begin
            if (full_chk || out_valid !== (sz != 0) || count !== 2'(sz) || in_ready !== (sz != 2)) begin
                chk("count", {62'd0, count}, 64'(sz));
                chk("out_valid", {63'd0, out_valid}, {63'd0, sz != 0});
                chk("in_ready", {63'd0, in_ready}, {63'd0, sz != 2});
            end
            if (sz != 0 && (full_chk || out_data !== sb_q[0]))
                chk("out_data", out_data, sb_q[0]);
            if (prev_stall && out_data !== prev_data)
                chk("stall_hold", out_data, prev_data);
            // Toggle out_ready within the cycle. in_ready must not move.
            ir_before = in_ready;
            out_ready = ~ordy;
            #1;
            if (full_chk || in_ready !== ir_before)
                chk("ir_comb", {63'd0, in_ready}, {63'd0, ir_before});
            out_ready = ordy;
            #1;
            if (int'(count) > max_count) max_count = int'(count);
        end
        in_f  = iv && (sz < 2);
        out_f = ordy && (sz != 0);
        prev_stall = (sz != 0) && !ordy && !fl && !rst;
        prev_data  = (sz != 0) ? sb_q[0] : '0;
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
            model_ok   = 1'b1;
            prev_stall = 1'b0;
        end else if (fl) begin
            if (out_f) n_out++;
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (out_f) begin
                void'(sb_q.pop_front());
                n_out++;
            end
            if (in_f) sb_q.push_back(id);
        end
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); #1;

        // Reset: two cycles with a word offered.
        step(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_count", {62'd0, count}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_data", out_data, 64'd0);

        // Streaming: 1, 2, 3, 4 on back-to-back cycles.
        for (int i = 1; i <= 4; i++)
            step(1'b1, 64'(i), 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Backpressure: A and B fill the block. C is held off, then everything drains.
        step(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_count", {62'd0, count}, 64'd2);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        step(1'b1, 64'hC, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hC, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("bp_drained", {62'd0, count}, 64'd0);

        // Simultaneous: ONE holding 5, with 6 accepted while 5 leaves.
        step(1'b1, 64'h5, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h6, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sim_data", out_data, 64'h6);
        chk("sim_count", {62'd0, count}, 64'd1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Flush from FULL while 9 is offered.
        step(1'b1, 64'h7, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h8, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h9, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("fl_count", {62'd0, count}, 64'd0);
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 {$urandom, $urandom},
                 ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 999) < 5) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0,
                 1'b0);
        end
        // Drain, with a bounded number of cycles.
        for (int i = 0; i < 4; i++)
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("final_empty", 64'(sb_q.size()), 64'd0);
        chk("max_count_le2", {63'd0, max_count <= 2}, 64'd1);
        chk("words_out", {63'd0, n_out > 1000}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
